// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch queue.
// Entry layout, state encoding and the NOP used for faulting slots.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        RUN,
        DRAIN
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
        logic            fault;
        logic            done;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_entry_ram.sv
// Register array of fetch entries.
// Allocation and fill write ports, async head read, per-slot done flags.
module fetch_entry_ram
    import fetch_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_en,
    input  logic [ADDR_W-1:0] alloc_idx,
    input  fetch_entry_t      alloc_entry,
    input  logic              fill_en,
    input  logic [ADDR_W-1:0] fill_idx,
    input  logic [XLEN-1:0]   fill_instr,
    input  logic [ADDR_W-1:0] rd_idx,
    output fetch_entry_t      rd_entry,
    output logic [DEPTH-1:0]  done_vec
);

    fetch_entry_t mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (alloc_en) begin
                mem[alloc_idx] <= alloc_entry;
            end
            if (fill_en) begin
                mem[fill_idx].instr <= fill_instr;
                mem[fill_idx].fault <= 1'b0;
                mem[fill_idx].done  <= 1'b1;
            end
        end
    end

    assign rd_entry = mem[rd_idx];

    always_comb begin
        done_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            done_vec[i] = mem[i].done;
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// In-order fetch queue between the PC stage and decode.
// Tracks outstanding imem reads and discards stale responses after a flush.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             fetch_valid,
    input  logic [WIDTH-1:0] fetch_pc,
    output logic             fetch_ready,
    output logic             imem_req_valid,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_req_ready,
    input  logic             imem_rsp_valid,
    input  logic [WIDTH-1:0] imem_rsp_data,
    output logic             dec_valid,
    input  logic             dec_ready,
    output logic [WIDTH-1:0] dec_pc,
    output logic [WIDTH-1:0] dec_pc_plus4,
    output logic [WIDTH-1:0] dec_instr,
    output logic             dec_fault
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int CNT_W  = ADDR_W + 4;

    logic [PTR_W-1:0] alloc_ptr, fill_ptr, head_ptr;
    logic [PTR_W-1:0] fill_tgt;
    logic [CNT_W-1:0] out_cnt, drop_cnt, drop_n, stale;
    state_e           state, state_n;

    logic aligned, full, empty;
    logic accept, req_hs, deq, fill_en;
    logic [DEPTH-1:0] done_vec;
    fetch_entry_t     alloc_e, head_e;

    assign aligned = (fetch_pc[1:0] == 2'b00);
    assign full    = ((alloc_ptr - head_ptr) == PTR_W'(DEPTH));
    assign empty   = (alloc_ptr == head_ptr);

    assign fetch_ready    = !flush && !full
                          && (aligned ? imem_req_ready : 1'b1);
    assign imem_req_valid = fetch_valid && !flush && !full && aligned;
    assign imem_req_addr  = fetch_pc;

    assign accept  = fetch_valid && fetch_ready;
    assign req_hs  = imem_req_valid && imem_req_ready;
    assign fill_en = imem_rsp_valid && (state == RUN) && !flush;

    assign dec_valid    = !empty && head_e.done;
    assign dec_pc       = head_e.pc;
    assign dec_pc_plus4 = head_e.pc_plus4;
    assign dec_instr    = head_e.instr;
    assign dec_fault    = head_e.fault;
    assign deq          = dec_valid && dec_ready && !flush;

    always_comb begin
        alloc_e          = '0;
        alloc_e.pc       = fetch_pc;
        alloc_e.pc_plus4 = fetch_pc + WIDTH'(4);
        alloc_e.instr    = aligned ? '0 : NOP_INSTR;
        alloc_e.fault    = !aligned;
        alloc_e.done     = !aligned;
    end

    // First slot at or after fill_ptr still waiting on memory;
    // misaligned slots are already done and get skipped here.
    always_comb begin
        logic             found;
        logic [PTR_W-1:0] p;
        fill_tgt = alloc_ptr;
        found    = 1'b0;
        p        = fill_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            p = fill_ptr + PTR_W'(i);
            if (!found && (p == alloc_ptr
                || !done_vec[p[ADDR_W-1:0]])) begin
                fill_tgt = p;
                found    = 1'b1;
            end
        end
    end

    fetch_entry_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk         (clk),
        .rst         (rst),
        .alloc_en    (accept),
        .alloc_idx   (alloc_ptr[ADDR_W-1:0]),
        .alloc_entry (alloc_e),
        .fill_en     (fill_en),
        .fill_idx    (fill_tgt[ADDR_W-1:0]),
        .fill_instr  (imem_rsp_data),
        .rd_idx      (head_ptr[ADDR_W-1:0]),
        .rd_entry    (head_e),
        .done_vec    (done_vec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            out_cnt   <= '0;
        end else begin
            out_cnt <= out_cnt + CNT_W'(req_hs)
                     - CNT_W'(imem_rsp_valid);
            if (flush) begin
                fill_ptr <= alloc_ptr;
                head_ptr <= alloc_ptr;
            end else begin
                if (accept) alloc_ptr <= alloc_ptr + 1'b1;
                fill_ptr <= fill_en ? fill_tgt + 1'b1 : fill_tgt;
                if (deq) head_ptr <= head_ptr + 1'b1;
            end
        end
    end

    // Everything still in flight after a flush belongs to dead slots.
    assign stale = out_cnt - CNT_W'(imem_rsp_valid);

    always_comb begin
        state_n = state;
        drop_n  = drop_cnt;
        if (flush) begin
            drop_n  = stale;
            state_n = (stale != '0) ? DRAIN : RUN;
        end else if (state == DRAIN && imem_rsp_valid) begin
            drop_n = drop_cnt - CNT_W'(1);
            if (drop_cnt == CNT_W'(1)) state_n = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            drop_cnt <= '0;
        end else begin
            state    <= state_n;
            drop_cnt <= drop_n;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue.
// In-order memory model plus an expected-entry scoreboard checked at dequeue.
module tb_instr_fetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, flush, fetch_valid, fetch_ready;
    logic [31:0] fetch_pc;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        dec_valid, dec_ready, dec_fault;
    logic [31:0] dec_pc, dec_pc_plus4, dec_instr;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    exp_t  exp_q [$];
    mreq_t mem_q [$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    int    lat    = 1;

    instr_fetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .fetch_ready    (fetch_ready),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_pc         (dec_pc),
        .dec_pc_plus4   (dec_pc_plus4),
        .dec_instr      (dec_instr),
        .dec_fault      (dec_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory returns ~addr, in order, lat cycles after the request.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (rst || mem_q.size() == 0 || mem_q[0].due > cyc) begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end else begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~mem_q[0].addr;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            mem_q.delete();
        end else begin
            if (dec_valid && dec_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    chk("deq_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("dec_pc", dec_pc, e.pc);
                    chk("dec_pc_plus4", dec_pc_plus4, e.pc + 32'd4);
                    chk("dec_instr", dec_instr, e.instr);
                    chk("dec_fault", 32'(dec_fault), 32'(e.fault));
                end
            end
            if (flush) exp_q.delete();
            if (fetch_valid && fetch_ready) begin
                exp_t e;
                e.pc    = fetch_pc;
                e.fault = (fetch_pc[1:0] != 2'b00);
                e.instr = e.fault ? NOP : ~fetch_pc;
                exp_q.push_back(e);
            end
            if (imem_req_valid && imem_req_ready) begin
                mreq_t m;
                m.addr = imem_req_addr;
                m.due  = cyc + lat;
                mem_q.push_back(m);
            end
            if (imem_rsp_valid && mem_q.size() != 0) begin
                void'(mem_q.pop_front());
            end
        end
    end

    task automatic push_fetch(input logic [31:0] pc);
        logic ok;
        int   n;
        ok          = 1'b0;
        n           = 0;
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        while (!ok && n < 20) begin
            ok = fetch_ready;
            tick();
            n++;
        end
        fetch_valid = 1'b0;
        chk("fetch_accept", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mem_q.size() != 0) && n < 60) begin
            tick();
            n++;
        end
        chk("drain_done", 32'(n < 60), 32'd1);
    endtask

    initial begin
        int acc;
        rst            = 1'b1;
        flush          = 1'b0;
        fetch_valid    = 1'b0;
        fetch_pc       = '0;
        imem_req_ready = 1'b1;
        dec_ready      = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        tick();
        tick();
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_dec_pc", dec_pc, 32'd0);
        rst = 1'b0;
        tick();

        // in-order stream, 1-cycle memory
        lat       = 1;
        dec_ready = 1'b1;
        push_fetch(32'h0);
        push_fetch(32'h4);
        push_fetch(32'h8);
        drain();

        // fill to full with decode stalled, then free one slot
        dec_ready   = 1'b0;
        acc         = 0;
        fetch_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            fetch_pc = 32'h200 + 32'(4 * acc);
            if (fetch_ready) acc++;
            tick();
        end
        chk("full_accepts", 32'(acc), 32'd4);
        chk("full_fetch_ready", 32'(fetch_ready), 32'd0);
        tick();
        tick();
        chk("full_dec_valid", 32'(dec_valid), 32'd1);
        chk("full_req_valid", 32'(imem_req_valid), 32'd0);
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        chk("freed_fetch_ready", 32'(fetch_ready), 32'd1);
        fetch_valid = 1'b0;
        dec_ready   = 1'b1;
        drain();

        // flush with three reads in flight
        lat = 3;
        push_fetch(32'h300);
        push_fetch(32'h304);
        push_fetch(32'h308);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_dec_valid", 32'(dec_valid), 32'd0);
        push_fetch(32'h100);
        drain();

        // misaligned PC: no request, NOP with fault
        lat         = 1;
        fetch_valid = 1'b1;
        fetch_pc    = 32'h102;
        #1;
        chk("misaligned_req", 32'(imem_req_valid), 32'd0);
        push_fetch(32'h102);
        drain();

        // mixed aligned/misaligned with pipelined 3-cycle memory
        lat = 3;
        push_fetch(32'h400);
        push_fetch(32'h402);
        push_fetch(32'h406);
        push_fetch(32'h408);
        push_fetch(32'h40C);
        drain();

        // pc+4 wrap and pointer wrap under continuous flow
        lat = 1;
        push_fetch(32'hFFFF_FFFC);
        drain();
        for (int i = 0; i < 10; i++) begin
            push_fetch(32'h500 + 32'(4 * i));
        end
        drain();

        // reset with buffered entries
        dec_ready = 1'b0;
        push_fetch(32'h600);
        push_fetch(32'h604);
        tick();
        tick();
        chk("pre_rst_dec_valid", 32'(dec_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_mid_fetch_ready", 32'(fetch_ready), 32'd1);
        chk("rst_mid_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        dec_ready = 1'b1;
        push_fetch(32'h700);
        drain();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
